// File: rtl/bk_mem_arbiter.sv
// BK single-port SRAM arbiter: sequences video word fetches and CPU bus cycles with fixed latency.
// Optional macro BKARB_FAIRSHARE_EN alternates video and CPU grants under contention.
module bk_mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned VADR_W      = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_rd,
   input  logic              cpu_wt,
   input  logic              cpu_byte,
   input  logic [15:0]       cpu_adr,
   input  logic [15:0]       cpu_data_i,
   output logic [15:0]       cpu_data_o,
   output logic              cpu_reply,
   input  logic              vid_req,
   input  logic [VADR_W-1:0] vid_adr,
   output logic [15:0]       vid_data,
   output logic              vid_ack,
   output logic [14:0]       sram_adr,
   output logic [15:0]       sram_data_o,
   input  logic [15:0]       sram_data_i,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [1:0]        sram_be
);

   typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU, S_REPLY} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYCLES - 1);

   state_t            state_q;
   logic [2:0]        cnt_q;
   logic              vid_pend_q;
   logic [VADR_W-1:0] vid_adr_q;
   logic [15:0]       cpu_data_q;
   logic              cpu_reply_q;
   logic [15:0]       vid_data_q;
   logic              vid_ack_q;
   logic [14:0]       sram_adr_q;
   logic [15:0]       sram_data_q;
   logic              sram_oe_q;
   logic              sram_we_q;
   logic [1:0]        sram_be_q;
`ifdef BKARB_FAIRSHARE_EN
   logic              last_vid_q;
`endif

   logic              vid_pend_d;
   logic [VADR_W-1:0] vid_adr_d;
   logic              cpu_pend;
   logic              grant_vid;
   logic [1:0]        cpu_be_d;

   // A request pulse on this very edge counts as pending, so a simultaneous
   // video pulse and CPU strobe still give video the first slot.
   always_comb begin
      vid_pend_d = vid_pend_q | vid_req;
      vid_adr_d  = vid_req ? vid_adr : vid_adr_q;
      cpu_pend   = cpu_rd | cpu_wt;
`ifdef BKARB_FAIRSHARE_EN
      grant_vid  = vid_pend_d & ~(cpu_pend & last_vid_q);
`else
      grant_vid  = vid_pend_d;
`endif
      if (!cpu_wt || !cpu_byte) begin
         cpu_be_d = 2'b11;
      end else if (cpu_adr[0]) begin
         cpu_be_d = 2'b10;
      end else begin
         cpu_be_d = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         vid_pend_q  <= 1'b0;
         vid_adr_q   <= '0;
         cpu_data_q  <= '0;
         cpu_reply_q <= 1'b0;
         vid_data_q  <= '0;
         vid_ack_q   <= 1'b0;
         sram_adr_q  <= '0;
         sram_data_q <= '0;
         sram_oe_q   <= 1'b0;
         sram_we_q   <= 1'b0;
         sram_be_q   <= '0;
`ifdef BKARB_FAIRSHARE_EN
         last_vid_q  <= 1'b0;
`endif
      end else begin
         vid_ack_q  <= 1'b0;
         vid_pend_q <= vid_pend_d;
         vid_adr_q  <= vid_adr_d;
         case (state_q)
            S_IDLE: begin
               if (grant_vid) begin
                  state_q    <= S_VID;
                  vid_pend_q <= 1'b0;
                  sram_adr_q <= 15'(vid_adr_d);
                  sram_oe_q  <= 1'b1;
                  sram_we_q  <= 1'b0;
                  sram_be_q  <= 2'b11;
                  cnt_q      <= CNT_LOAD;
`ifdef BKARB_FAIRSHARE_EN
                  last_vid_q <= 1'b1;
`endif
               end else if (cpu_pend) begin
                  state_q    <= S_CPU;
                  sram_adr_q <= cpu_adr[15:1];
                  sram_oe_q  <= ~cpu_wt;
                  sram_we_q  <= cpu_wt;
                  sram_be_q  <= cpu_be_d;
                  if (cpu_wt) begin
                     sram_data_q <= cpu_data_i;
                  end
                  cnt_q      <= CNT_LOAD;
`ifdef BKARB_FAIRSHARE_EN
                  last_vid_q <= 1'b0;
`endif
               end
            end
            S_VID: begin
               if (cnt_q == '0) begin
                  vid_data_q <= sram_data_i;
                  vid_ack_q  <= 1'b1;
                  sram_oe_q  <= 1'b0;
                  sram_be_q  <= '0;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_CPU: begin
               if (cnt_q == '0) begin
                  if (!sram_we_q) begin
                     cpu_data_q <= sram_data_i;
                  end
                  sram_oe_q <= 1'b0;
                  sram_we_q <= 1'b0;
                  sram_be_q <= '0;
                  // A strobe dropped mid-access gets no reply; the SRAM cycle still ran to completion.
                  if (cpu_pend) begin
                     cpu_reply_q <= 1'b1;
                     state_q     <= S_REPLY;
                  end else begin
                     state_q     <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_REPLY: begin
               if (!cpu_pend) begin
                  cpu_reply_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cpu_data_o  = cpu_data_q;
   assign cpu_reply   = cpu_reply_q;
   assign vid_data    = vid_data_q;
   assign vid_ack     = vid_ack_q;
   assign sram_adr    = sram_adr_q;
   assign sram_data_o = sram_data_q;
   assign sram_oe     = sram_oe_q;
   assign sram_we     = sram_we_q;
   assign sram_be     = sram_be_q;

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Bench for bk_mem_arbiter: directed literal cases plus randomized traffic against a timestamp-based access model.
module tb_bk_mem_arbiter;
   localparam int W = 2;
`ifdef BKARB_FAIRSHARE_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_rd, cpu_wt, cpu_byte;
   logic [15:0] cpu_adr, cpu_data_i, cpu_data_o;
   logic        cpu_reply;
   logic        vid_req;
   logic [14:0] vid_adr;
   logic [15:0] vid_data;
   logic        vid_ack;
   logic [14:0] sram_adr;
   logic [15:0] sram_data_o, sram_data_i;
   logic        sram_oe, sram_we;
   logic [1:0]  sram_be;

   logic        ovr_en;
   logic [15:0] ovr_val;
   bit          chk_en;
   int          checks;
   int          failures;

   // Reference access model: an in-flight access is a timestamped record.
   int          edge_n;
   bit          a_v, a_vid, a_wr;
   int          a_start;
   logic [14:0] a_adr;
   logic [1:0]  a_be;
   logic [15:0] a_wdata;
   bit          pend, last_vid;
   logic [14:0] padr;
   bit          m_reply, m_ack;
   logic [15:0] m_cpu_data, m_vid_data;

   always #5 clk = ~clk;

   function automatic logic [15:0] hash(input logic [14:0] a);
      return {a[6:0], a[14:6]} ^ 16'hC3A5;
   endfunction

   function automatic logic [15:0] rd_val(input logic [14:0] a);
      return ovr_en ? ovr_val : hash(a);
   endfunction

   assign sram_data_i = ovr_en ? ovr_val : hash(sram_adr);

   bk_mem_arbiter #(.WAIT_CYCLES(W), .VADR_W(15)) dut (
      .clk(clk), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_byte(cpu_byte),
      .cpu_adr(cpu_adr), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .cpu_reply(cpu_reply),
      .vid_req(vid_req), .vid_adr(vid_adr), .vid_data(vid_data), .vid_ack(vid_ack),
      .sram_adr(sram_adr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
      .sram_oe(sram_oe), .sram_we(sram_we), .sram_be(sram_be)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_step();
      bit          np, cpu_req, vwin;
      logic [14:0] npadr;
      edge_n++;
      if (reset) begin
         a_v = 0; m_reply = 0; m_ack = 0; pend = 0; last_vid = 0;
         padr = '0; m_cpu_data = '0; m_vid_data = '0;
      end else begin
         m_ack   = 0;
         np      = pend | vid_req;
         npadr   = vid_req ? vid_adr : padr;
         cpu_req = cpu_rd | cpu_wt;
         if (a_v && edge_n == a_start + W) begin
            if (a_vid) begin
               m_vid_data = rd_val(a_adr);
               m_ack = 1;
            end else begin
               if (!a_wr) m_cpu_data = rd_val(a_adr);
               m_reply = cpu_req;
            end
            a_v = 0;
         end else if (m_reply) begin
            if (!cpu_req) m_reply = 0;
         end else if (!a_v) begin
            vwin = np && !(FAIR && cpu_req && last_vid);
            if (vwin) begin
               a_v = 1; a_vid = 1; a_wr = 0; a_start = edge_n;
               a_adr = npadr; a_be = 2'b11;
               np = 0; last_vid = 1;
            end else if (cpu_req) begin
               a_v = 1; a_vid = 0; a_wr = cpu_wt; a_start = edge_n;
               a_adr = cpu_adr[15:1]; a_wdata = cpu_data_i;
               a_be = (cpu_wt && cpu_byte) ? (cpu_adr[0] ? 2'b10 : 2'b01) : 2'b11;
               last_vid = 0;
            end
         end
         pend = np;
         padr = npadr;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cpu_reply", cpu_reply, m_reply);
         chk("vid_ack", vid_ack, m_ack);
         chk("cpu_data_o", cpu_data_o, m_cpu_data);
         chk("vid_data", vid_data, m_vid_data);
         chk("sram_oe", sram_oe, a_v && !a_wr);
         chk("sram_we", sram_we, a_v && a_wr);
         chk("sram_be", sram_be, a_v ? a_be : 2'b00);
         chk("oe_we_excl", sram_oe & sram_we, 0);
         if (a_v) chk("sram_adr", sram_adr, a_adr);
         if (a_v && a_wr) chk("sram_data_o", sram_data_o, a_wdata);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [15:0] adr, input logic byt,
                           input logic [15:0] dat, input logic [1:0] exp_be);
      cpu_wt = 1; cpu_byte = byt; cpu_adr = adr; cpu_data_i = dat;
      tick();
      chk("wr_we1", sram_we, 1);
      chk("wr_oe", sram_oe, 0);
      chk("wr_be", sram_be, exp_be);
      chk("wr_data", sram_data_o, dat);
      chk("wr_adr", sram_adr, adr[15:1]);
      tick();
      chk("wr_we2", sram_we, 1);
      tick();
      chk("wr_we_end", sram_we, 0);
      chk("wr_reply", cpu_reply, 1);
      cpu_wt = 0; cpu_byte = 0;
      tick();
      chk("wr_reply_drop", cpu_reply, 0);
   endtask

   initial begin
      bit seen;
      bit cpu_busy, early;
      int age;
      reset = 1; cpu_rd = 0; cpu_wt = 0; cpu_byte = 0; cpu_adr = '0; cpu_data_i = '0;
      vid_req = 0; vid_adr = '0; ovr_en = 0; ovr_val = '0;
      checks = 0; failures = 0; chk_en = 0;
      tick();
      chk_en = 1;
      tick();
      chk("rst_cpu_data", cpu_data_o, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_reply", cpu_reply, 0);
      chk("rst_ack", vid_ack, 0);
      chk("rst_sram_adr", sram_adr, 0);
      chk("rst_sram_dout", sram_data_o, 0);
      chk("rst_sram_ctl", {sram_oe, sram_we, sram_be}, 0);
      reset = 0;
      tick();

      // Word read at byte address 'o001000
      ovr_en = 1; ovr_val = 16'h1234;
      cpu_rd = 1; cpu_adr = 16'o001000;
      tick();
      chk("rd_oe1", sram_oe, 1);
      chk("rd_adr", sram_adr, 15'o000400);
      chk("rd_be", sram_be, 2'b11);
      tick();
      chk("rd_oe2", sram_oe, 1);
      tick();
      chk("rd_oe_end", sram_oe, 0);
      chk("rd_reply", cpu_reply, 1);
      chk("rd_data", cpu_data_o, 16'h1234);
      tick();
      chk("rd_reply_hold", cpu_reply, 1);
      cpu_rd = 0;
      tick();
      chk("rd_reply_drop", cpu_reply, 0);

      do_write(16'o001001, 1'b1, 16'hA5A5, 2'b10);
      do_write(16'o001000, 1'b1, 16'h5A5A, 2'b01);
      do_write(16'o001002, 1'b0, 16'h1357, 2'b11);

      // Simultaneous video pulse and CPU read
      ovr_val = 16'hBEEF;
      vid_req = 1; vid_adr = 15'h0123; cpu_rd = 1; cpu_adr = 16'o002000;
      tick();
      vid_req = 0;
      chk("vc_vid_oe", sram_oe, 1);
      chk("vc_vid_adr", sram_adr, 15'h0123);
      tick();
      tick();
      chk("vc_ack", vid_ack, 1);
      chk("vc_vid_data", vid_data, 16'hBEEF);
      ovr_val = 16'h0F0F;
      tick();
      chk("vc_ack_pulse", vid_ack, 0);
      chk("vc_cpu_oe", sram_oe, 1);
      chk("vc_cpu_adr", sram_adr, 15'o001000);
      tick();
      chk("vc_reply_early", cpu_reply, 0);
      tick();
      chk("vc_reply_c6", cpu_reply, 1);
      chk("vc_cpu_data", cpu_data_o, 16'h0F0F);
      cpu_rd = 0;
      tick();
      ovr_en = 0;

      // Continuous video traffic against a held CPU read
      seen = 0;
      cpu_rd = 1; cpu_adr = 16'o004000;
      for (int i = 0; i < 40; i++) begin
         vid_req = (i % (W + 1) == 0);
         vid_adr = 15'($urandom);
         tick();
         if (cpu_reply) seen = 1;
      end
      vid_req = 0;
      chk("contention_reply", seen, FAIR);
      for (int k = 0; k < 40 && !cpu_reply; k++) tick();
      chk("contention_final_reply", cpu_reply, 1);
      cpu_rd = 0;
      repeat (8) tick();

      // Write strobe dropped after one access cycle
      cpu_wt = 1; cpu_byte = 0; cpu_adr = 16'o003000; cpu_data_i = 16'h7E57;
      tick();
      chk("early_we1", sram_we, 1);
      cpu_wt = 0;
      tick();
      chk("early_we2", sram_we, 1);
      tick();
      chk("early_we_end", sram_we, 0);
      chk("early_no_reply", cpu_reply, 0);
      tick();
      chk("early_no_reply2", cpu_reply, 0);

      // Reset in the middle of a video access with a second request pending
      vid_req = 1; vid_adr = 15'h0400;
      tick();
      chk("rv_oe", sram_oe, 1);
      vid_adr = 15'h0555;
      tick();
      vid_req = 0; reset = 1;
      tick();
      chk("rv_ctl_after_reset", {sram_oe, sram_we, sram_be}, 0);
      chk("rv_no_ack", vid_ack, 0);
      chk("rv_vid_data", vid_data, 0);
      reset = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rv_pend_cleared", sram_oe | vid_ack, 0);
      end
      vid_req = 1; vid_adr = 15'h0666;
      tick();
      vid_req = 0;
      chk("rv_new_oe", sram_oe, 1);
      chk("rv_new_adr", sram_adr, 15'h0666);
      tick();
      tick();
      chk("rv_new_ack", vid_ack, 1);
      chk("rv_new_data", vid_data, hash(15'h0666));

      // Randomized traffic, checked every cycle by the model
      cpu_busy = 0; early = 0; age = 0;
      for (int c = 0; c < 1500; c++) begin
         vid_req = ($urandom_range(0, 3) == 0);
         vid_adr = 15'($urandom);
         if (!cpu_busy) begin
            if ($urandom_range(0, 2) == 0) begin
               cpu_wt     = 1'($urandom_range(0, 1));
               cpu_rd     = !cpu_wt || ($urandom_range(0, 7) == 0);
               cpu_byte   = 1'($urandom_range(0, 1));
               cpu_adr    = 16'($urandom);
               cpu_data_i = 16'($urandom);
               early      = ($urandom_range(0, 9) == 0);
               age        = 0;
               cpu_busy   = 1;
            end
         end else begin
            age++;
            if (cpu_reply || (early && age == 2) || age > 100) begin
               cpu_rd = 0; cpu_wt = 0; cpu_busy = 0;
            end
         end
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 0; cpu_rd = 0; cpu_wt = 0; vid_req = 0;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
